// File: rtl/gray_to_binary_decoder.sv
// gray_to_binary_decoder
//   Bit-serial gray-to-binary decoder for gray-coded counter/pointer streams.
//   Accepts one WIDTH-bit gray word per in_valid/in_ready handshake, resolves
//   it MSB first at one bit per clock, then presents the binary word and a
//   step-error flag on an out_valid/out_ready handshake.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   gray_in holds a word to accept
//   in_ready   decoder can accept (high only while idle)
//   gray_in    gray-coded input word
//   out_valid  bin_out/step_err valid
//   out_ready  downstream accepts the result
//   bin_out    decoded binary word
//   step_err   accepted code was not a one-bit step from the previous one
module gray_to_binary_decoder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] gray_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] bin_out,
    output logic             step_err
);

    localparam int unsigned IW      = $clog2(WIDTH);
    localparam logic [IW-1:0] IDX_MAX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
    logic             hist_v_q, hist_v_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] bin_work_q, bin_work_d;
    logic             step_err_pend_q, step_err_pend_d;
    logic [WIDTH-1:0] bin_out_q, bin_out_d;
    logic             step_err_q, step_err_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    // Zero above the MSB lets every bit use bin[i+1] ^ gray[i], including the top one.
    logic [WIDTH:0]   bin_ext;

    always_comb begin
        state_d         = state_q;
        gray_d          = gray_q;
        prev_gray_d     = prev_gray_q;
        hist_v_d        = hist_v_q;
        idx_d           = idx_q;
        bin_work_d      = bin_work_q;
        step_err_pend_d = step_err_pend_q;
        bin_out_d       = bin_out_q;
        step_err_d      = step_err_q;
        out_valid_d     = out_valid_q;
        in_ready_d      = in_ready_q;
        bin_ext         = {1'b0, bin_work_q};

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    gray_d          = gray_in;
                    // Distance 0 (repeat) and distance >= 2 are both errors.
                    step_err_pend_d = hist_v_q && ($countones(gray_in ^ prev_gray_q) != 1);
                    prev_gray_d     = gray_in;
                    hist_v_d        = 1'b1;
                    idx_d           = IDX_MAX;
                    in_ready_d      = 1'b0;
                    state_d         = S_CONV;
                end
            end

            S_CONV: begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (idx_q == IW'(i)) begin
                        bin_work_d[i] = bin_ext[i+1] ^ gray_q[i];
                    end
                end
                if (idx_q == '0) begin
                    bin_out_d   = bin_work_d;
                    step_err_d  = step_err_pend_q;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            gray_q          <= '0;
            prev_gray_q     <= '0;
            hist_v_q        <= 1'b0;
            idx_q           <= IDX_MAX;
            bin_work_q      <= '0;
            step_err_pend_q <= 1'b0;
            bin_out_q       <= '0;
            step_err_q      <= 1'b0;
            out_valid_q     <= 1'b0;
            in_ready_q      <= 1'b1;
        end else begin
            state_q         <= state_d;
            gray_q          <= gray_d;
            prev_gray_q     <= prev_gray_d;
            hist_v_q        <= hist_v_d;
            idx_q           <= idx_d;
            bin_work_q      <= bin_work_d;
            step_err_pend_q <= step_err_pend_d;
            bin_out_q       <= bin_out_d;
            step_err_q      <= step_err_d;
            out_valid_q     <= out_valid_d;
            in_ready_q      <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign bin_out   = bin_out_q;
    assign step_err  = step_err_q;

endmodule
